// File: rtl/jtkunio_pcm_pkg.sv
// Shared definitions for the PCM sample fetch controller.
// No logic of its own; zero latency.
// No flow control involved.
package jtkunio_pcm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        PLAY  = 2'd3
    } pcm_state_t;

    localparam logic [1:0] REG_START = 2'd0;
    localparam logic [1:0] REG_END   = 2'd1;
    localparam logic [1:0] REG_BANK  = 2'd2;
    localparam logic [1:0] REG_CMD   = 2'd3;

    // Advance the ROM byte address; only the low 16 bits count, so the bank bit never changes.
    function automatic logic [16:0] bump_addr(input logic [16:0] a);
        return {a[16], a[15:0] + 16'd1};
    endfunction

endpackage

// File: rtl/jtkunio_pcm_fifo.sv
// Two-entry byte buffer: head slot feeds the player, second slot holds the prefetch.
// Push/pop take effect at the clock edge; dout shows the head with zero latency.
// Pushes into a full buffer (without a pop) and pops from an empty one are ignored.
module jtkunio_pcm_fifo #(
    parameter int DW = 8
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] head;
    logic [DW-1:0] tail;
    logic [1:0]    cnt;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (cnt == 2'd0);
    assign full    = (cnt == 2'd2);
    assign dout    = head;
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Shift-style storage: the head is always the oldest byte.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (cnt == 2'd0) head <= din;
                    else             tail <= din;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        head <= din;
                    end else begin
                        head <= tail;
                        tail <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/jtkunio_pcm_ctrl.sv
// ADPCM sample fetcher: reads ROM bytes between start/end pages and feeds nibbles per vclk.
// Nibble appears the cycle after vclk; first ROM request issues two cycles after a start write.
// pcm_cs holds until pcm_ok; fetching stalls while both buffer slots are full.
module jtkunio_pcm_ctrl
    import jtkunio_pcm_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 17
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vclk,
    input  logic          wr,
    input  logic [1:0]    addr,
    input  logic [7:0]    din,
    output logic [AW-1:0] pcm_addr,
    output logic          pcm_cs,
    input  logic [DW-1:0] pcm_data,
    input  logic          pcm_ok,
    output logic [3:0]    adpcm_din,
    output logic          adpcm_rst,
    output logic          busy,
    output logic          underrun
);

    pcm_state_t    state;
    pcm_state_t    state_nx;
    logic [7:0]    start_pg;
    logic [7:0]    end_pg;
    logic          bank;
    logic [16:0]   rd_addr;
    logic [16:0]   end_addr;
    logic          req;
    logic          last_fetched;
    logic          phase;
    logic          cmd_wr;
    logic          start_wr;
    logic          stop_wr;
    logic          accept;
    logic          play_vclk;
    logic          pop;
    logic          last_nib;
    logic [DW-1:0] head;
    logic          full;
    logic          empty;

    // A command write wins over everything else happening in the same cycle.
    assign cmd_wr    = wr && (addr == REG_CMD);
    assign start_wr  = cmd_wr && din[0];
    assign stop_wr   = cmd_wr && !din[0];
    assign accept    = req && pcm_ok && ((state == WAIT) || (state == PLAY)) && !cmd_wr;
    assign play_vclk = vclk && (state == PLAY) && !empty && !cmd_wr;
    assign pop       = play_vclk && phase;
    // Once the end byte is fetched no more pushes come, so a single buffered byte is the end byte.
    assign last_nib  = pop && last_fetched && !full;

    assign pcm_cs   = req;
    assign busy     = (state != IDLE);
    assign pcm_addr = AW'(rd_addr);

    jtkunio_pcm_fifo #(.DW(DW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (cmd_wr),
        .push  (accept),
        .din   (pcm_data),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: initial fill goes FETCH -> WAIT -> PLAY; commands override.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = IDLE;
            FETCH:   state_nx = WAIT;
            WAIT:    if (accept) state_nx = PLAY;
            PLAY:    if (last_nib) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (start_wr)     state_nx = FETCH;
        else if (stop_wr) state_nx = IDLE;
    end

    // Registers, ROM request/address tracking and nibble output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_pg     <= 8'h00;
            end_pg       <= 8'h00;
            bank         <= 1'b0;
            rd_addr      <= 17'd0;
            end_addr     <= 17'd0;
            req          <= 1'b0;
            last_fetched <= 1'b0;
            phase        <= 1'b0;
            adpcm_din    <= 4'h0;
            adpcm_rst    <= 1'b1;
            underrun     <= 1'b0;
        end else begin
            if (wr) begin
                case (addr)
                    REG_START: start_pg <= din;
                    REG_END:   end_pg   <= din;
                    REG_BANK:  bank     <= din[0];
                    default:   ;
                endcase
            end
            if (start_wr) begin
                // Dropping req for the FETCH cycle lets any ok left over from an aborted request lapse.
                rd_addr      <= {bank, start_pg, 8'h00};
                end_addr     <= {bank, end_pg, 8'hFF};
                req          <= 1'b0;
                last_fetched <= 1'b0;
                phase        <= 1'b0;
                underrun     <= 1'b0;
                adpcm_rst    <= 1'b0;
            end else if (stop_wr) begin
                req   <= 1'b0;
                phase <= 1'b0;
            end else begin
                if (state == FETCH) begin
                    req <= 1'b1;
                end else if (accept) begin
                    req     <= 1'b0;
                    rd_addr <= bump_addr(rd_addr);
                    if (rd_addr == end_addr) last_fetched <= 1'b1;
                end else if ((state == PLAY) && !req && !full && !last_fetched) begin
                    req <= 1'b1;
                end
                if (play_vclk) begin
                    adpcm_din <= phase ? head[3:0] : head[7:4];
                    phase     <= !phase;
                end
                if (vclk && (state != IDLE) && empty) underrun  <= 1'b1;
                if (vclk && (state == IDLE))          adpcm_rst <= 1'b1;
            end
        end
    end

endmodule

// File: doc/jtkunio_pcm_ctrl.md
JTKUNIO_PCM_CTRL -- requirements
Module: jtkunio_pcm_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8, meaning PCM ROM data width in bits.
REQ-002 SHALL have parameter AW, default 17, meaning PCM ROM byte-address width in bits.
REQ-003 clk  in  1  system clock; all logic SHALL be synchronous to its rising edge.
REQ-004 rst_n  in  1  reset; one clock, reset is synchronous and active-low.
REQ-005 vclk  in  1  one-cycle pulse on clk, one per ADPCM nibble request.
REQ-006 wr  in  1  one-cycle sound-CPU write strobe.
REQ-007 addr  in  2  register select.
REQ-008 din  in  8  sound-CPU write data.
REQ-009 pcm_addr  out  AW  ROM byte address.
REQ-010 pcm_cs  out  1  ROM request; held high until pcm_ok is sampled high.
REQ-011 pcm_data  in  DW  ROM byte; valid when pcm_ok=1 and pcm_cs=1.
REQ-012 pcm_ok  in  1  ROM data valid.
REQ-013 adpcm_din  out  4  nibble to ADPCM decoder.
REQ-014 adpcm_rst  out  1  decoder reset; high whenever not playing.
REQ-015 busy  out  1  high while playing.
REQ-016 underrun  out  1  sticky flag: vclk arrived with no byte buffered.

Function
REQ-017 Registers: 0 = start page (start[15:8]); 1 = end page (end[15:8]); 2 = bank (din[0] -> address bit 16); 3 = command.
REQ-018 Start address SHALL be {bank,start_page,8'h00}; end address SHALL be {bank,end_page,8'hFF}, inclusive.
REQ-019 Command write with din[0]=1 SHALL start playback next cycle; din[0]=0 SHALL stop playback next cycle.
REQ-020 States: IDLE, FETCH, WAIT, PLAY; IDLE->FETCH on start; FETCH asserts pcm_cs; WAIT holds pcm_cs until pcm_ok; then PLAY.
REQ-021 A one-byte buffer plus a one-byte prefetch SHALL be kept; the next byte SHALL be requested as soon as the prefetch slot is empty and the address is not past end.
REQ-022 In PLAY, each vclk SHALL output the high nibble first, then the low nibble on the following vclk; after the low nibble the buffer SHALL load from the prefetch.
REQ-023 adpcm_din SHALL change only on the cycle after vclk and hold between pulses.
REQ-024 Address counter SHALL increment low 16 bits only, wrapping 16'hFFFF->16'h0000 within the bank, and continue until the end address byte is consumed.
REQ-025 After the low nibble of the end byte is output, the FSM SHALL return to IDLE, drop busy, and assert adpcm_rst on the next vclk.
REQ-026 vclk with an empty buffer SHALL hold adpcm_din, set underrun, and not advance the nibble phase.
REQ-027 underrun SHALL clear only on a command start write.
REQ-028 Start while busy SHALL abort the current fetch and restart from the new start address, discarding any buffered bytes; a pending pcm_ok for the aborted request SHALL be ignored.
REQ-029 If wr to reg 3 and the final-nibble vclk coincide, the write SHALL take precedence.
REQ-030 Register writes to 0-2 during playback SHALL take effect only on the next start.
REQ-031 pcm_cs SHALL never drop while pcm_ok is low, except on stop or restart.

Reset
REQ-032 While rst_n=0: state=IDLE, pcm_cs=0, pcm_addr=0, adpcm_din=0, adpcm_rst=1, busy=0, underrun=0, registers=0, buffers empty.
REQ-033 Reset asserted mid-fetch SHALL abandon the request; the first cycle after release SHALL be IDLE.

Structure
REQ-034 State encoding and register-index constants SHALL live in a shared package, jtkunio_pcm_pkg.
REQ-035 One sub-module, jtkunio_pcm_fifo (2-entry byte buffer with full/empty flags), SHALL be used.

Verification
REQ-036 Start page 0x10, end page 0x10, bank 0, ROM byte = address[7:0] -> 512 nibbles out; the first two are 0x0 then 0x0, nibbles 3-4 are 0x0 then 0x1; the last nibble pair is 0xF,0xF; busy falls after nibble 512.
REQ-037 Start page 0xFF, end page 0x00, bank 1 -> addresses run 0x1FF00..0x1FFFF then 0x10000..0x100FF; pcm_addr[16] stays 1 throughout.
REQ-038 pcm_ok delayed 40 cycles with vclk every 8 cycles -> underrun=1 and adpcm_din held; a subsequent start write clears underrun.
REQ-039 Start command at byte 0x05 of playback -> next pcm_addr = new start; the stale pcm_ok is ignored; the first nibble output is from the new start.
REQ-040 rst_n low for 1 cycle during WAIT -> pcm_cs=0 and adpcm_rst=1 next cycle; no further requests until a start write.
